linear_interpolator: RTL and testbench
======================================

# linear_interpolator

- Upsamples a low-rate 16-bit signed audio stream by 2^RATIO_LOG2 using linear interpolation. Produces one output sample per LRCK period.
- Mirrors the decimator in the I2S audio path: sits between the decimated-sample source and the parallel-to-serial transmitter.
- Accepts one input sample per output period (IN_VALID strobe). Flags underrun and overrun.

## Interface
- RATIO_LOG2, default 3: interpolation ratio R = 2^RATIO_LOG2 output samples per input sample. Legal range 1..8.
- LRCK  input  1  single clock, the audio frame clock. All state updates on the falling edge.
- RST_N  input  1  asynchronous, active-low reset.
- AUD_IN  input  16  input sample, two's complement. Captured on an edge where IN_VALID=1.
- IN_VALID  input  1  new input sample present this edge.
- AUD_OUT  output  16  interpolated output sample, two's complement, registered.
- OUT_SYNC  output  1  one-cycle pulse: a new segment started with a newly consumed sample.
- UNDERRUN  output  1  one-cycle pulse: a segment boundary was reached with no pending sample.
- OVERRUN  output  1  one-cycle pulse: a pending sample was overwritten before it was consumed.

## Operation
- Registers:
  - pend[15:0] and pend_v: one-deep input buffer.
  - T[15:0]: current segment target.
  - delta: 17-bit signed.
  - acc: (16+RATIO_LOG2)-bit signed.
  - phase: RATIO_LOG2 bits.
  - state: IDLE or RUN.
- AUD_OUT = acc[RATIO_LOG2+15:RATIO_LOG2], an arithmetic shift right, i.e. floor.
- Input capture, every edge:
  - If IN_VALID=1: pend<=AUD_IN and pend_v<=1.
  - If pend_v was already 1 and pend is not consumed on this edge: OVERRUN=1. The new value wins.
- Consume and capture on the same edge: old pend is used, new value is stored, pend_v stays 1, no OVERRUN.
- Consume without capture clears pend_v.
- IDLE, phase held at 0:
  - Edge with pend_v=1: T<=pend, acc<=pend<<RATIO_LOG2, delta<=0, phase<=0, OUT_SYNC=1, go to RUN.
  - Otherwise stay in IDLE with AUD_OUT=0 and no UNDERRUN.
- RUN, non-boundary edge (phase != R-1): acc<=acc+delta, phase<=phase+1.
- RUN, boundary edge (phase == R-1): phase<=0 and acc<=T<<RATIO_LOG2, so the old target is output exactly. Then:
  - If pend_v=1: delta<=pend-T (17-bit signed), T<=pend, OUT_SYNC=1.
  - Else: delta<=0, T unchanged, UNDERRUN=1. Output holds T for the whole segment.
- Result: within a segment, AUD_OUT at phase p = floor(T_old + p*(T_new-T_old)/R). The endpoints are exact.
- Arithmetic never overflows: every output is a convex combination of two 16-bit values. No saturation logic is required.
- RUN is exited only by reset.

## Timing
- Reset (asynchronous on RST_N low, released synchronously to the next falling edge):
  - AUD_OUT=0, OUT_SYNC=0, UNDERRUN=0, OVERRUN=0.
  - acc=0, delta=0, T=0, pend_v=0, phase=0, state=IDLE.
- Reset mid-segment takes effect immediately. The pending sample is discarded.
- Capture to buffer: a sample presented with IN_VALID on edge e is consumable from edge e+1.
- First sample: captured on edge e0, it appears on AUD_OUT after edge e0+1.
- Steady state: a sample consumed at boundary edge b is reached exactly on AUD_OUT at boundary b+R. Pipeline lag is one input period.
- Pulse timing: OUT_SYNC, UNDERRUN and OVERRUN are high for exactly one LRCK period following the causing edge.
- OUT_SYNC and UNDERRUN are mutually exclusive.

## Test plan
- Reset/idle: RST_N low, then high; IN_VALID=0 for 20 edges -> AUD_OUT=0 and all flags 0 throughout.
- First sample and ramp (R=8): 0x0000 at e0, then 0x0800 one period later -> AUD_OUT=0x0000 for 8 edges, then 0x0000, 0x0100, ..., 0x0700, then 0x0800 at the next boundary. OUT_SYNC pulses at each boundary.
- Negative and floor: T=0x0000, next sample 0xFFF9 (-7) -> phases 1..7 output 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC, 0xFFFB, 0xFFFA, 0xFFF9; boundary output 0xFFF9.
- Full scale: 0x7FFF then 0x8000 -> phase 4 outputs 0xFFFF, the boundary reaches 0x8000 exactly, and no wrap glitch occurs anywhere in the ramp.
- Flow errors:
  - Underrun: no sample at a boundary -> UNDERRUN pulse; AUD_OUT holds T for 8 edges.
  - Overrun: two IN_VALID strobes (0x1000, then 0x2000) within one segment -> OVERRUN pulse; the segment ramps to 0x2000.
- Reset mid-ramp at phase 3 -> AUD_OUT=0 immediately. The next sample restarts the IDLE->RUN sequence.

Source files
------------

// File: rtl/linear_interpolator.sv
// linear_interpolator: upsamples a 16-bit signed stream by 2^RATIO_LOG2 with linear ramps
// Ports:
//   lrck      frame clock; all state updates on its falling edge
//   rst_n     asynchronous active-low reset
//   aud_in    input sample, two's complement, captured when in_valid=1
//   in_valid  new input sample present on this edge
//   aud_out   interpolated output sample, floor of the scaled accumulator
//   out_sync  one-cycle pulse: a segment started with a newly consumed sample
//   underrun  one-cycle pulse: segment boundary reached with no pending sample
//   overrun   one-cycle pulse: a pending sample was overwritten unconsumed
module linear_interpolator #(
    parameter int RATIO_LOG2 = 3
) (
    input  logic        lrck,
    input  logic        rst_n,
    input  logic [15:0] aud_in,
    input  logic        in_valid,
    output logic [15:0] aud_out,
    output logic        out_sync,
    output logic        underrun,
    output logic        overrun
);
    localparam int AW = 16 + RATIO_LOG2;
    typedef enum logic {IDLE, RUN} state_t;
    state_t                 state;
    logic [15:0]            pend;
    logic                   pend_v;
    logic [15:0]            tgt;
    logic signed [16:0]     delta;
    logic signed [AW-1:0]   acc;
    logic [RATIO_LOG2-1:0]  phase;
    logic                   boundary;
    logic                   consume;
    logic signed [AW-1:0]   pend_scaled;
    logic signed [AW-1:0]   tgt_scaled;
    logic signed [AW-1:0]   delta_ext;
    logic signed [16:0]     diff;
    assign boundary    = (state == RUN) && (phase == {RATIO_LOG2{1'b1}});
    assign consume     = pend_v && ((state == IDLE) || boundary);
    assign pend_scaled = {pend, {RATIO_LOG2{1'b0}}};
    assign tgt_scaled  = {tgt, {RATIO_LOG2{1'b0}}};
    assign delta_ext   = AW'(delta);
    // 17-bit difference cannot overflow for any pair of 16-bit samples
    assign diff        = {pend[15], pend} - {tgt[15], tgt};
    assign aud_out     = acc[AW-1:RATIO_LOG2];
    always_ff @(negedge lrck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            pend_v   <= 1'b0;
            tgt      <= '0;
            delta    <= '0;
            acc      <= '0;
            phase    <= '0;
            out_sync <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            out_sync <= 1'b0;
            underrun <= 1'b0;
            if (in_valid) pend <= aud_in;
            // a capture on the consuming edge refills the buffer without loss
            pend_v  <= in_valid || (pend_v && !consume);
            overrun <= in_valid && pend_v && !consume;
            if (state == IDLE) begin
                if (pend_v) begin
                    tgt      <= pend;
                    acc      <= pend_scaled;
                    delta    <= '0;
                    phase    <= '0;
                    out_sync <= 1'b1;
                    state    <= RUN;
                end
            end else if (boundary) begin
                // land exactly on the old target, then aim at the next one
                phase <= '0;
                acc   <= tgt_scaled;
                if (pend_v) begin
                    delta    <= diff;
                    tgt      <= pend;
                    out_sync <= 1'b1;
                end else begin
                    delta    <= '0;
                    underrun <= 1'b1;
                end
            end else begin
                acc   <= acc + delta_ext;
                phase <= phase + RATIO_LOG2'(1);
            end
        end
    end
endmodule

// File: tb/tb_linear_interpolator.sv
// tb_linear_interpolator: directed checks of the R=8 linear interpolator
module tb_linear_interpolator;
    logic        lrck = 1'b1;
    logic        rst_n = 1'b0;
    logic [15:0] aud_in = '0;
    logic        in_valid = 1'b0;
    logic [15:0] aud_out;
    logic        out_sync;
    logic        underrun;
    logic        overrun;
    int          checks = 0;
    int          failures = 0;

    linear_interpolator #(.RATIO_LOG2(3)) dut (
        .lrck     (lrck),
        .rst_n    (rst_n),
        .aud_in   (aud_in),
        .in_valid (in_valid),
        .aud_out  (aud_out),
        .out_sync (out_sync),
        .underrun (underrun),
        .overrun  (overrun)
    );

    always #5 lrck = ~lrck;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        in_valid = v;
        aud_in   = d;
        @(negedge lrck);
        #1;
    endtask

    // one segment ramping a -> b; nd is strobed on phase 7 when nv is set,
    // es is whether the boundary edge is expected to consume a sample
    task automatic seg(input logic [15:0] a, input logic [15:0] b, input logic nv,
                       input logic [15:0] nd, input logic es);
        int num;
        for (int p = 1; p < 8; p++) begin
            step(nv && p == 7, nd);
            num = $signed(a) * 8 + p * ($signed(b) - $signed(a));
            check("ramp_out", aud_out, 16'(num >>> 3));
            check("ramp_flags", {out_sync, underrun, overrun}, 3'b000);
        end
        step(1'b0, 16'h0);
        check("bnd_out", aud_out, b);
        check("bnd_flags", {out_sync, underrun, overrun}, {es, !es, 1'b0});
    endtask

    initial begin
        step(1'b0, 16'h0);
        check("rst_out", aud_out, 16'h0);
        check("rst_flags", {out_sync, underrun, overrun}, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0);
            check("idle_out", aud_out, 16'h0);
            check("idle_flags", {out_sync, underrun, overrun}, 3'b000);
        end
        step(1'b1, 16'h0000);
        check("first_cap_out", aud_out, 16'h0);
        check("first_cap_flags", {out_sync, underrun, overrun}, 3'b000);
        step(1'b0, 16'h0);
        check("first_out", aud_out, 16'h0);
        check("first_flags", {out_sync, underrun, overrun}, 3'b100);
        seg(16'h0000, 16'h0000, 1'b1, 16'h0800, 1'b1);
        seg(16'h0000, 16'h0800, 1'b1, 16'h0000, 1'b1);
        seg(16'h0800, 16'h0000, 1'b1, 16'hFFF9, 1'b1);
        seg(16'h0000, 16'hFFF9, 1'b1, 16'h7FFF, 1'b1);
        seg(16'hFFF9, 16'h7FFF, 1'b1, 16'h8000, 1'b1);
        seg(16'h7FFF, 16'h8000, 1'b0, 16'h0000, 1'b0);
        // held segment with two strobes inside it and a third on the boundary
        for (int p = 1; p < 8; p++) begin
            step(p == 2 || p == 5, (p == 2) ? 16'h1000 : 16'h2000);
            check("ovr_hold", aud_out, 16'h8000);
            check("ovr_flag", {15'h0, overrun}, (p == 5) ? 16'h1 : 16'h0);
        end
        step(1'b1, 16'h3000);
        check("ovr_bnd_out", aud_out, 16'h8000);
        check("ovr_bnd_flags", {out_sync, underrun, overrun}, 3'b100);
        seg(16'h8000, 16'h2000, 1'b0, 16'h0000, 1'b1);
        seg(16'h2000, 16'h3000, 1'b0, 16'h0000, 1'b0);
        seg(16'h3000, 16'h3000, 1'b1, 16'h1000, 1'b1);
        step(1'b0, 16'h0);
        check("mid_p1", aud_out, 16'h2C00);
        step(1'b0, 16'h0);
        check("mid_p2", aud_out, 16'h2800);
        step(1'b1, 16'h5555);
        check("mid_p3", aud_out, 16'h2400);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", aud_out, 16'h0);
        check("mid_rst_flags", {out_sync, underrun, overrun}, 3'b000);
        step(1'b0, 16'h0);
        rst_n = 1'b1;
        step(1'b0, 16'h0);
        check("post_rst_idle", aud_out, 16'h0);
        check("post_rst_flags", {out_sync, underrun, overrun}, 3'b000);
        step(1'b1, 16'h0400);
        check("restart_cap", aud_out, 16'h0);
        step(1'b0, 16'h0);
        check("restart_out", aud_out, 16'h0400);
        check("restart_flags", {out_sync, underrun, overrun}, 3'b100);
        step(1'b0, 16'h0);
        check("restart_p1", aud_out, 16'h0400);
        check("restart_p1_flags", {out_sync, underrun, overrun}, 3'b000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
